hex_page_sequencer: RTL and testbench
=====================================

HEX_PAGE_SEQUENCER -- requirements
Module: hex_page_sequencer

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000000: clocks each page is shown (min 1).
REQ-002 SHALL have parameter GAP_CYCLES, default 5000000: blank clocks between pages (0 = no gap).
REQ-003 SHALL have parameter BLINK_CYCLES, default 25000000: blink half-period (used only with HEX_PAGE_BLINK_EN).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  3  Avalon-MM slave word address.
REQ-007 write  input  1  write strobe, one access per cycle.
REQ-008 writedata  input  32  write data.
REQ-009 read  input  1  read strobe.
REQ-010 readdata  output  32  read data, registered.
REQ-011 value  output  32  nibble-packed word for the hex display datapath, digit0 = bits[3:0].
REQ-012 blank  output  8  per-digit blank, bit n = digit n dark.
REQ-013 page  output  2  index of page currently driven on value.

Function
REQ-014 Address map SHALL be: 0-3 PAGE0-3 (R/W, 32 b); 4 CTRL (R/W: bit0 EN, bits[2:1] LAST page index, bit3 HOLD); 5 SEL (R/W, bits[1:0] manual page); 6 STATUS (RO: bits[1:0] page, bits[5:4] state); 7 BLINK mask (see Configuration).
REQ-015 readdata SHALL be valid the cycle after read=1; unread/unused bits read 0; write to STATUS ignored.
REQ-016 FSM states SHALL be STOP (0), SHOW (1), GAP (2).
REQ-017 STOP: page = SEL, value = PAGEn[SEL], blank = 0; dwell/gap counters held at 0.
REQ-018 STOP -> SHOW on cycle after EN written 1: page = 0, dwell counter loaded DWELL_CYCLES-1.
REQ-019 SHOW: counter decrements each cycle unless HOLD=1 (frozen); at 0 -> GAP if GAP_CYCLES>0 else directly SHOW next page.
REQ-020 GAP: blank = 8'hFF, value still the outgoing page; after GAP_CYCLES cycles -> SHOW next page, counter reloaded.
REQ-021 Next page SHALL be page+1, wrapping to 0 when page >= LAST (also covers LAST lowered below current page).
REQ-022 Writing EN=0 in any state SHALL enter STOP on the next cycle, clearing counters.
REQ-023 Write to the page currently shown SHALL appear on value the cycle after the write.
REQ-024 value/blank/page SHALL be registered: change exactly one cycle after the causing event.
REQ-025 Simultaneous write to CTRL and dwell expiry: CTRL write wins (EN=0 -> STOP; else advance with new LAST).
REQ-026 Counters SHALL be width $clog2 of their parameter, no overflow; dwell counter never wraps below 0.

Reset
REQ-027 On reset: PAGE0-3=0, CTRL=0, SEL=0, BLINK=0, state STOP, counters 0, value=0, blank=0, page=0, readdata=0.
REQ-028 Reset asserted mid-sequence SHALL return all outputs to reset values immediately (asynchronous), resume only via new EN write.

Configuration
REQ-029 Macro HEX_PAGE_BLINK_EN defined: address 7 holds 8-bit BLINK mask; a phase bit toggles every BLINK_CYCLES (runs in all states); in phase 1 blank |= mask.
REQ-030 HEX_PAGE_BLINK_EN undefined: no blink counter; address 7 writes ignored, reads 0; blank driven only by GAP.

Verification (DWELL_CYCLES=4, GAP_CYCLES=2, BLINK_CYCLES=3)
REQ-031 Reset, write PAGE0=32'h12345678 with EN=0, SEL=0 -> value=32'h12345678 next cycle, blank=0, page=0.
REQ-032 PAGE0..2 = 1,2,3, CTRL=0x5 (EN, LAST=2) -> page sequence 0(4 clk), blank FF(2 clk), 1, gap, 2, gap, 0.
REQ-033 Running at page 2, write CTRL LAST=1 -> after dwell/gap page wraps to 0; STATUS reads page and state 1/2 matching.
REQ-034 HOLD=1 during SHOW page 1 for 10 cycles -> page stays 1, no GAP; clear HOLD -> remaining dwell completes.
REQ-035 Write EN=0 in cycle of dwell expiry -> state STOP next cycle, blank=0, value=PAGE[SEL]; assert reset mid-GAP -> all outputs 0 immediately.
REQ-036 With HEX_PAGE_BLINK_EN, BLINK=8'h0F in STOP -> blank alternates 00/0F every 3 cycles; without macro blank stays 00, address 7 reads 0.

Source files
------------

// File: rtl/hex_page_sequencer.sv
// Avalon-MM controlled page sequencer: cycles up to four 32-bit pages onto a hex display datapath.
// Optional per-digit blink mask is compiled in with HEX_PAGE_BLINK_EN.
module hex_page_sequencer #(
   parameter int unsigned DWELL_CYCLES = 50000000,
   parameter int unsigned GAP_CYCLES   = 5000000,
   parameter int unsigned BLINK_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic        read,
   output logic [31:0] readdata,
   output logic [31:0] value,
   output logic [7:0]  blank,
   output logic [1:0]  page
);

   localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   if (DWELL_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
      $error("hex_page_sequencer: DWELL_CYCLES and BLINK_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0][31:0]  pages_q, pages_d;
   logic              en_q, en_d, hold_q, hold_d;
   logic [1:0]        last_q, last_d, sel_q, sel_d;
   logic [1:0]        page_q, page_d, next_pg;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [31:0]       value_q, value_d, readdata_q, readdata_d;
   logic [7:0]        blank_q, blank_d;
   logic              ctrl_wr;

`ifdef HEX_PAGE_BLINK_EN
   localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic [7:0]    mask_q, mask_d;

   always_comb begin
      mask_d  = mask_q;
      bcnt_d  = bcnt_q + 1'b1;
      phase_d = phase_q;
      if (write && address == 3'd7) mask_d = writedata[7:0];
      if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q  <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end
`endif

   // Register file write decode
   always_comb begin
      pages_d = pages_q;
      en_d    = en_q;
      last_d  = last_q;
      hold_d  = hold_q;
      sel_d   = sel_q;
      ctrl_wr = write && (address == 3'd4);
      if (write) begin
         case (address)
            3'd0, 3'd1, 3'd2, 3'd3: pages_d[address[1:0]] = writedata;
            3'd4: begin
               en_d   = writedata[0];
               last_d = writedata[2:1];
               hold_d = writedata[3];
            end
            3'd5:    sel_d = writedata[1:0];
            default: ;
         endcase
      end
   end

   // Sequencer; next-page and output values use post-write register contents so
   // a same-cycle CTRL/PAGE write takes effect on the very next output update.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      dwell_d = dwell_q;
      gap_d   = gap_q;
      next_pg = (page_q >= last_d) ? 2'd0 : page_q + 2'd1;
      case (state_q)
         ST_SHOW: begin
            if (!hold_q) begin
               if (dwell_q == '0) begin
                  if (GAP_CYCLES > 0) begin
                     state_d = ST_GAP;
                     gap_d   = GAP_LOAD;
                  end else begin
                     page_d  = next_pg;
                     dwell_d = DWELL_LOAD;
                  end
               end else begin
                  dwell_d = dwell_q - 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               state_d = ST_SHOW;
               page_d  = next_pg;
               dwell_d = DWELL_LOAD;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            dwell_d = '0;
            gap_d   = '0;
            page_d  = sel_d;
            if (ctrl_wr && writedata[0]) begin
               state_d = ST_SHOW;
               page_d  = 2'd0;
               dwell_d = DWELL_LOAD;
            end
         end
      endcase
      if (ctrl_wr && !writedata[0]) begin
         state_d = ST_STOP;
         page_d  = sel_d;
         dwell_d = '0;
         gap_d   = '0;
      end

      value_d = pages_d[page_d];
      blank_d = (state_d == ST_GAP) ? 8'hFF : 8'h00;
`ifdef HEX_PAGE_BLINK_EN
      if (phase_d) blank_d = blank_d | mask_d;
`endif

      readdata_d = readdata_q;
      if (read) begin
         case (address)
            3'd0, 3'd1, 3'd2, 3'd3: readdata_d = pages_q[address[1:0]];
            3'd4:    readdata_d = {28'd0, hold_q, last_q, en_q};
            3'd5:    readdata_d = {30'd0, sel_q};
            3'd6:    readdata_d = {26'd0, state_q, 2'b00, page_q};
`ifdef HEX_PAGE_BLINK_EN
            default: readdata_d = {24'd0, mask_q};
`else
            default: readdata_d = '0;
`endif
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_STOP;
         pages_q    <= '0;
         en_q       <= 1'b0;
         last_q     <= '0;
         hold_q     <= 1'b0;
         sel_q      <= '0;
         page_q     <= '0;
         dwell_q    <= '0;
         gap_q      <= '0;
         value_q    <= '0;
         blank_q    <= '0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         pages_q    <= pages_d;
         en_q       <= en_d;
         last_q     <= last_d;
         hold_q     <= hold_d;
         sel_q      <= sel_d;
         page_q     <= page_d;
         dwell_q    <= dwell_d;
         gap_q      <= gap_d;
         value_q    <= value_d;
         blank_q    <= blank_d;
         readdata_q <= readdata_d;
      end
   end

   assign value    = value_q;
   assign blank    = blank_q;
   assign page     = page_q;
   assign readdata = readdata_q;

endmodule

// File: tb/tb_hex_page_sequencer.sv
// Self-checking bench for hex_page_sequencer (DWELL=4, GAP=2, BLINK=3): register table,
// readback scoreboard, and hand-written dwell/gap/hold/stop/reset sequences.
module tb_hex_page_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = '0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic        read = 1'b0;
   logic [31:0] readdata;
   logic [31:0] value;
   logic [7:0]  blank;
   logic [1:0]  page;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] sb[$];
   logic        rd_seen = 1'b0;

   hex_page_sequencer #(
      .DWELL_CYCLES(4),
      .GAP_CYCLES  (2),
      .BLINK_CYCLES(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .address  (address),
      .write    (write),
      .writedata(writedata),
      .read     (read),
      .readdata (readdata),
      .value    (value),
      .blank    (blank),
      .page     (page)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Readback scoreboard: a read sampled at one edge is compared on the following negedge.
   always @(posedge clk) rd_seen <= read && !reset;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got readdata %h with no expected entry", readdata);
         end else begin
            check("readdata", readdata, sb.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      write = 1'b1;
      address = a;
      writedata = d;
      @(posedge clk);
      #1;
      write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp);
      read = 1'b1;
      address = a;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      read = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rd_exp;
      logic [31:0] val_exp;
      logic [1:0]  pg_exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int   cnt_on;
      int   cnt_off;
      logic [1:0] pg;

      vecs[0]  = '{3'd0, 32'h12345678, 32'h12345678, 32'h12345678, 2'd0};
      vecs[1]  = '{3'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 2'd0};
      vecs[2]  = '{3'd5, 32'h00000001, 32'h00000001, 32'hDEADBEEF, 2'd1};
      vecs[3]  = '{3'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'd1};
      vecs[4]  = '{3'd5, 32'hFFFFFFFF, 32'h00000003, 32'hA5A5A5A5, 2'd3};
      vecs[5]  = '{3'd2, 32'h0BADF00D, 32'h0BADF00D, 32'hA5A5A5A5, 2'd3};
      vecs[6]  = '{3'd6, 32'hFFFFFFFF, 32'h00000003, 32'hA5A5A5A5, 2'd3};
      vecs[7]  = '{3'd4, 32'hFFFFFFF0, 32'h00000000, 32'hA5A5A5A5, 2'd3};
`ifdef HEX_PAGE_BLINK_EN
      vecs[8]  = '{3'd7, 32'hFFFFFFFF, 32'h000000FF, 32'hA5A5A5A5, 2'd3};
`else
      vecs[8]  = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 2'd3};
`endif
      vecs[9]  = '{3'd7, 32'h00000000, 32'h00000000, 32'hA5A5A5A5, 2'd3};
      vecs[10] = '{3'd5, 32'h00000000, 32'h00000000, 32'h12345678, 2'd0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_value", value, 32'h0);
      check("rst_blank", {24'd0, blank}, 32'h0);
      check("rst_page", {30'd0, page}, 32'h0);
      check("rst_readdata", readdata, 32'h0);
      reset = 1'b0;
      idle(1);

      // Register table in STOP: write, observe value/page next cycle, read back
      for (int i = 0; i < 11; i++) begin
         wr(vecs[i].addr, vecs[i].wdata);
         check($sformatf("tbl%0d_value", i), value, vecs[i].val_exp);
         check($sformatf("tbl%0d_page", i), {30'd0, page}, {30'd0, vecs[i].pg_exp});
`ifndef HEX_PAGE_BLINK_EN
         check($sformatf("tbl%0d_blank", i), {24'd0, blank}, 32'h0);
`endif
         rd(vecs[i].addr, vecs[i].rd_exp);
      end

      // Run pages 0..2: 4 show cycles then 2 blank cycles per page
      wr(3'd0, 32'd1);
      wr(3'd1, 32'd2);
      wr(3'd2, 32'd3);
      wr(3'd4, 32'h5);
      for (int t = 0; t < 12; t++) begin
         pg = (t < 6) ? 2'd0 : 2'd1;
         check($sformatf("seq_t%0d_page", t), {30'd0, page}, {30'd0, pg});
         check($sformatf("seq_t%0d_value", t), value, {30'd0, pg} + 32'd1);
         check($sformatf("seq_t%0d_blank", t), {24'd0, blank},
               ((t % 6) >= 4) ? 32'hFF : 32'h0);
         idle(1);
      end
      check("seq_p2_page", {30'd0, page}, 32'd2);
      check("seq_p2_value", value, 32'd3);

      // Lower LAST below current page while showing page 2
      wr(3'd4, 32'h3);
      rd(3'd6, 32'h12);
      idle(2);
      check("last_gap_blank", {24'd0, blank}, 32'hFF);
      check("last_gap_page", {30'd0, page}, 32'd2);
      rd(3'd6, 32'h22);
      idle(1);
      check("last_wrap_page", {30'd0, page}, 32'd0);
      check("last_wrap_value", value, 32'd1);
      check("last_wrap_blank", {24'd0, blank}, 32'h0);
      idle(6);
      check("p1_page", {30'd0, page}, 32'd1);

      // HOLD freezes dwell on page 1, then remaining dwell completes
      wr(3'd4, 32'hB);
      for (int t = 0; t < 10; t++) begin
         check($sformatf("hold%0d_page", t), {30'd0, page}, 32'd1);
         check($sformatf("hold%0d_blank", t), {24'd0, blank}, 32'h0);
         idle(1);
      end
      wr(3'd4, 32'h3);
      check("unhold0_blank", {24'd0, blank}, 32'h0);
      idle(2);
      check("unhold2_blank", {24'd0, blank}, 32'h0);
      check("unhold2_page", {30'd0, page}, 32'd1);
      idle(1);
      check("unhold_gap_blank", {24'd0, blank}, 32'hFF);
      idle(2);
      check("unhold_next_page", {30'd0, page}, 32'd0);
      check("unhold_next_blank", {24'd0, blank}, 32'h0);

      // EN=0 written in the dwell-expiry cycle
      wr(3'd5, 32'h2);
      idle(2);
      wr(3'd4, 32'h2);
      check("stop_page", {30'd0, page}, 32'd2);
      check("stop_value", value, 32'd3);
      check("stop_blank", {24'd0, blank}, 32'h0);
      rd(3'd6, 32'h02);
      idle(6);
      check("stop_hold_page", {30'd0, page}, 32'd2);
      check("stop_hold_blank", {24'd0, blank}, 32'h0);

      // Asynchronous reset mid-GAP
      wr(3'd4, 32'h1);
      check("restart_page", {30'd0, page}, 32'd0);
      check("restart_value", value, 32'd1);
      idle(4);
      check("pre_rst_blank", {24'd0, blank}, 32'hFF);
      #2;
      reset = 1'b1;
      #1;
      check("arst_value", value, 32'h0);
      check("arst_blank", {24'd0, blank}, 32'h0);
      check("arst_page", {30'd0, page}, 32'h0);
      check("arst_readdata", readdata, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(3);
      check("post_rst_value", value, 32'h0);
      check("post_rst_blank", {24'd0, blank}, 32'h0);
      rd(3'd6, 32'h0);
      rd(3'd0, 32'h0);

      // Blink mask
      wr(3'd7, 32'h0F);
`ifdef HEX_PAGE_BLINK_EN
      cnt_on = 0;
      cnt_off = 0;
      for (int t = 0; t < 12; t++) begin
         if (blank == 8'h0F) cnt_on++;
         else if (blank == 8'h00) cnt_off++;
         idle(1);
      end
      check("blink_on_cycles", cnt_on, 32'd6);
      check("blink_off_cycles", cnt_off, 32'd6);
      rd(3'd7, 32'h0F);
`else
      cnt_on = 0;
      cnt_off = 0;
      for (int t = 0; t < 6; t++) begin
         check($sformatf("noblink%0d_blank", t), {24'd0, blank}, 32'h0);
         idle(1);
      end
      rd(3'd7, 32'h0);
`endif

      idle(2);
      check("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
